// File: rtl/icache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILLED
    } icache_state_t;

    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int num_lines, input int words_per_line);
        return 32 - 2 - $clog2(words_per_line) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill sequencer: lookup/refill FSM, beat counter, latched line base and memory bus outputs.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  lookup_hit,
    input  logic [31:0]                           line_base,
    input  logic                                  mem_ack,
    output logic                                  idle,
    output logic                                  start,
    output logic                                  beat_wr,
    output logic                                  last_beat,
    output logic                                  filled,
    output logic [offset_width(WORDS_PER_LINE)-1:0] beat,
    output logic [31:0]                           fill_addr,
    output logic                                  mem_req,
    output logic [31:0]                           mem_addr
);

    localparam int OW = offset_width(WORDS_PER_LINE);
    localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

    icache_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            fill_addr <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                fill_addr <= line_base;
                beat      <= '0;
            end else if (beat_wr) begin
                // Wraps to zero after the last beat, ready for the next refill.
                beat <= beat + OW'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        beat_wr    = 1'b0;
        last_beat  = 1'b0;
        filled     = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (!lookup_hit) begin
                    start      = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr + (32'(beat) << 2);
                beat_wr  = mem_ack;
                if (mem_ack && beat == LAST_BEAT) begin
                    last_beat  = 1'b1;
                    state_next = FILLED;
                end
            end
            FILLED: begin
                filled     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign idle = (state == IDLE);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with combinational hit path and line refill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_dm
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_imem,
    output logic [31:0] imem_instn,
    output logic        Iwait,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OW = offset_width(WORDS_PER_LINE);
    localparam int IW = index_width(NUM_LINES);
    localparam int TW = tag_width(NUM_LINES, WORDS_PER_LINE);

    logic [OW-1:0] offset, beat;
    logic [IW-1:0] index, fill_index;
    logic [TW-1:0] tag, fill_tag;
    logic [31:0]   fill_addr;
    logic          idle, start, beat_wr, last_beat, filled, lookup_hit, hit;

    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES*WORDS_PER_LINE];

    assign offset     = pc_imem[OW+1:2];
    assign index      = pc_imem[IW+OW+1:OW+2];
    assign tag        = pc_imem[31:IW+OW+2];
    assign fill_index = fill_addr[IW+OW+1:OW+2];
    assign fill_tag   = fill_addr[31:IW+OW+2];

    logic unused_bits;
    assign unused_bits = ^{pc_imem[1:0], fill_addr[OW+1:0]};

    assign lookup_hit = valid[index] && (tags[index] == tag);
    assign hit        = idle && lookup_hit;
    assign Iwait      = !hit;
    assign imem_instn = hit ? data[{index, offset}] : '0;

    icache_refill_ctrl #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .lookup_hit (lookup_hit),
        .line_base  ({pc_imem[31:OW+2], {(OW+2){1'b0}}}),
        .mem_ack    (mem_ack),
        .idle       (idle),
        .start      (start),
        .beat_wr    (beat_wr),
        .last_beat  (last_beat),
        .filled     (filled),
        .beat       (beat),
        .fill_addr  (fill_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr)
    );

    // Valid is cleared at refill start so an aborted refill never exposes a partial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (start) begin
            valid[index] <= 1'b0;
        end else if (filled) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag and data storage has no reset; valid alone decides whether their contents count.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            data[{fill_index, beat}] <= mem_rdata;
        end
        if (last_beat) begin
            tags[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: vector table for miss/hit/eviction, hand sequences for
// ack back-pressure, reset mid-refill and (with ICACHE_STATS_EN) the statistics counters.
module tb_icache_dm;

    logic        clk;
    logic        reset;
    logic [31:0] pc_imem;
    logic [31:0] imem_instn;
    logic        Iwait;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache_dm dut (
        .clk        (clk),
        .reset      (reset),
        .pc_imem    (pc_imem),
        .imem_instn (imem_instn),
        .Iwait      (Iwait),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Backing memory: each word holds its own address.
    assign mem_rdata = mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic        iwait;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instn;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input logic ack, input logic iwait,
                                input logic req, input logic [31:0] addr, input logic [31:0] instn);
        vec_t v;
        v.pc = pc; v.ack = ack; v.iwait = iwait; v.req = req; v.addr = addr; v.instn = instn;
        return v;
    endfunction

    // Full miss on pc with ack tied high: detect, four beats, filled, then a hit.
    function automatic void push_miss(inout vec_t q[$], input logic [31:0] pc);
        logic [31:0] base;
        base = pc & ~32'hF;
        q.push_back(mk(pc, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
        for (int b = 0; b < 4; b++) begin
            q.push_back(mk(pc, 1'b1, 1'b1, 1'b1, base + 32'(4 * b), 32'h0));
        end
        q.push_back(mk(pc, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
        q.push_back(mk(pc, 1'b1, 1'b0, 1'b0, 32'h0, pc));
    endfunction

    // Fetch pc from cold, holding ack low for 'stall' cycles before each beat.
    task automatic fetch_miss(input logic [31:0] pc, input int stall, input int exp_cycles,
                              input string name);
        int cycles = 0;
        int beats  = 0;
        int w      = 0;
        logic [31:0] base;
        base    = pc & ~32'hF;
        pc_imem = pc;
        forever begin
            mem_ack = mem_req && (w >= stall);
            #1;
            if (!Iwait) break;
            if (mem_req) begin
                check($sformatf("%s.addr_c%0d", name, cycles), mem_addr, base + 32'(4 * beats));
                if (mem_ack) begin
                    beats++;
                    w = 0;
                end else begin
                    w++;
                end
            end
            cycles++;
            if (cycles > 200) begin
                check($sformatf("%s.timeout", name), 32'(cycles), 32'(exp_cycles));
                break;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check($sformatf("%s.penalty", name), 32'(cycles), 32'(exp_cycles));
        check($sformatf("%s.beats", name), 32'(beats), 32'd4);
        check($sformatf("%s.instn", name), imem_instn, pc);
    endtask

    vec_t vecs[$];

    initial begin
        // Cold miss, line reuse, conflict eviction and re-miss of the evicted line.
        push_miss(vecs, 32'h100);
        vecs.push_back(mk(32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h104));
        vecs.push_back(mk(32'h108, 1'b1, 1'b0, 1'b0, 32'h0, 32'h108));
        vecs.push_back(mk(32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10C));
        push_miss(vecs, 32'h500);
        push_miss(vecs, 32'h100);

        reset   = 1'b1;
        pc_imem = 32'h0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.iwait", 32'(Iwait), 32'd1);
        check("rst.req",   32'(mem_req), 32'd0);
        check("rst.addr",  mem_addr, 32'h0);
        check("rst.instn", imem_instn, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            pc_imem = vecs[i].pc;
            mem_ack = vecs[i].ack;
            #1;
            check($sformatf("vec%0d.iwait", i), 32'(Iwait), 32'(vecs[i].iwait));
            check($sformatf("vec%0d.req", i),   32'(mem_req), 32'(vecs[i].req));
            check($sformatf("vec%0d.addr", i),  mem_addr, vecs[i].addr);
            check($sformatf("vec%0d.instn", i), imem_instn, vecs[i].instn);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;

        // Back-pressure: 3 idle ack cycles before every beat gives 1 + 4*4 + 1 cycles.
        fetch_miss(32'h200, 3, 18, "bp");
        @(posedge clk); #1;

        // Reset during beat 2 of a refill.
        pc_imem = 32'h300;
        mem_ack = 1'b1;
        #1;
        check("rmid.iwait", 32'(Iwait), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rmid.beat2_addr", mem_addr, 32'h308);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rmid.req_drop", 32'(mem_req), 32'd0);
        check("rmid.addr_zero", mem_addr, 32'h0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        fetch_miss(32'h100, 0, 6, "rst_refetch");
        @(posedge clk); #1;

`ifdef ICACHE_STATS_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("stats.hit_rst",  hit_count, 32'd0);
        check("stats.miss_rst", miss_count, 32'd0);
        fetch_miss(32'h700, 0, 6, "stats_fill");
        @(posedge clk); #1;
        pc_imem = 32'h704;
        @(posedge clk); #1;
        pc_imem = 32'h708;
        @(posedge clk); #1;
        pc_imem = 32'h70C;
        @(posedge clk); #1;
        check("stats.hit_count",  hit_count, 32'd4);
        check("stats.miss_count", miss_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the 5-stage core's fetch port and backing instruction memory. Serves `pc_imem` lookups combinationally on a hit. On a miss it raises `Iwait` and refills the whole line over a word-per-beat request/ack bus. The core's hazard unit already stalls fetch on `Iwait`.

## Interface
- `NUM_LINES`, 64: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `pc_imem  in  32`: fetch address from the core; bits [1:0] ignored.
- `imem_instn  out  32`: instruction word; valid only when `Iwait`=0.
- `Iwait  out  1`: 1 = instruction not available; the core holds `pc_imem`.
- `mem_req  out  1`: refill beat request.
- `mem_addr  out  32`: word-aligned beat address.
- `mem_ack  in  1`: beat accepted; `mem_rdata` valid this cycle.
- `mem_rdata  in  32`: refill data.

## Operation
- Address split: offset = log2(WORDS_PER_LINE) bits above [1:0], then index = log2(NUM_LINES) bits, then tag = the remaining upper bits.
- Per line: valid bit, tag, data words.
- Hit = `state`==IDLE & valid[index] & tag match. On a hit, `imem_instn` = data[index][offset] and `Iwait`=0, in the same cycle.
- FSM `IDLE`:
  - On a miss, latch line base {tag, index, 0} into `fill_addr`, clear `beat`, clear valid[index], and go to `REFILL`.
  - `Iwait`=1 in any cycle that is not a hit.
- FSM `REFILL`:
  - `mem_req`=1 and `mem_addr`=`fill_addr`+4·`beat`.
  - On `mem_ack`, write `mem_rdata` to data[idx][beat] and increment `beat`.
  - On the ack of beat WORDS_PER_LINE−1, set the tag and go to `FILLED`.
  - `mem_req` stays high across beats; the address advances only on an ack.
- FSM `FILLED`:
  - Set valid[idx]; `Iwait`=1; go to `IDLE`.
  - Lookup then resumes on the current `pc_imem`.
- A `pc_imem` change during a refill does not abort it. The line completes, then the new pc is looked up and may miss again.
- Beat order is fixed, word 0 upward; there is no critical-word-first.
- There are no writes from the core and no coherence with data memory.

## Timing
- Reset values:
  - state=IDLE, all valid=0, `beat`=0, `mem_req`=0, `mem_addr`=0.
  - `Iwait` follows combinationally from a miss.
  - `imem_instn`=0 when not hitting.
- Hit latency: 0 cycles (combinational read).
- Miss penalty with `mem_ack` tied high: WORDS_PER_LINE+2 cycles of `Iwait`. That is 1 IDLE detect cycle, WORDS_PER_LINE REFILL beats, and 1 FILLED cycle. Each cycle of `mem_ack`=0 adds one cycle.
- Reset asserted mid-refill: next state is IDLE, `mem_req` drops the following cycle, all lines are invalid, and the partial line is discarded. Backing memory must tolerate an abandoned request.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration
- `ICACHE_STATS_EN` defined adds two output ports, each a 32-bit saturating counter cleared on reset:
  - `hit_count  out  32`: increments once per cycle in which hit=1.
  - `miss_count  out  32`: increments once per IDLE→REFILL transition.
- `ICACHE_STATS_EN` undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Package `icache_pkg` holds:
  - the `icache_state_t` enum {IDLE, REFILL, FILLED};
  - the localparam functions for offset, index and tag widths from the parameters.
- Sub-module `icache_refill_ctrl`: FSM, `beat` counter, `fill_addr`, and mem-bus outputs.
- Tag, valid and data arrays stay in the top module.

## Test plan
- Cold miss, `mem_ack`=1 constantly, pc=0x100, memory word = address:
  - `Iwait`=1 for 6 cycles;
  - `mem_addr` steps 0x100, 0x104, 0x108, 0x10C;
  - then `imem_instn`=0x10C is not expected; `imem_instn`=0x100 with `Iwait`=0.
- Line reuse: after the first test, pc = 0x104, 0x108, 0x10C → hits, `Iwait`=0, `mem_req`=0 throughout.
- Conflict eviction (defaults): fill 0x100, then fetch 0x500 (same index, different tag) → refill; a following 0x100 misses again.
- Ack back-pressure: `mem_ack` low 3 cycles before each beat → `mem_addr` stays stable while unacked; miss penalty = 18 cycles.
- Reset during beat 2 → valid cleared and `mem_req`=0 one cycle later; refetch of 0x100 misses and refills all 4 beats.
- With `ICACHE_STATS_EN`: 1 miss plus 3 hits on one line → `miss_count`=1, `hit_count`=4. The count of 4 includes the hit cycle after the fill.
